decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_if.sv | 31 +++
 rtl/decode_stage.sv | 121 ++++++++++++
 tb/tb_decode_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// decode_if: upstream/downstream handshake and decoded bundle of the decode stage
interface decode_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_ctrl;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctrl,
               is_load, is_store, is_branch, is_jump, illegal
    );
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctrl,
               is_load, is_store, is_branch, is_jump, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder behind a main register plus one-entry skid buffer
module decode_stage #(
    parameter int XLEN          = 32,
    parameter bit ILLEGAL_CHECK = 1'b1
) (
    input logic     clk,
    input logic     rst,
    decode_if.slave bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu;
        logic            ld;
        logic            st;
        logic            br;
        logic            jmp;
        logic            ill;
    } bundle_t;
    logic [31:0] ins;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        alt;
    logic        bad;
    logic        ill;
    logic [3:0]  alu_f3;
    logic [3:0]  alu_raw;
    logic [31:0] imm32;
    bundle_t     dec;
    bundle_t     main_q, main_d, skid_q, skid_d;
    logic        main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic        acc, cons, load_main;
    assign ins = bus.in_instr;
    assign op  = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];
    assign alt = f7 == 7'b0100000;
    always_comb begin
        alu_f3  = f3 == 3'd0 ? 4'd0 : f3 == 3'd1 ? 4'd5 : f3 == 3'd2 ? 4'd8 : f3 == 3'd3 ? 4'd9 :
                  f3 == 3'd4 ? 4'd2 : f3 == 3'd5 ? (alt ? 4'd7 : 4'd6) : f3 == 3'd6 ? 4'd3 : 4'd4;
        alu_raw = op == OP_R   ? ((f3 == 3'd0 && alt) ? 4'd1 : alu_f3) :
                  op == OP_IMM ? alu_f3 :
                  op == OP_BR  ? (f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1) : 4'd0;
        // Opcodes with instr[1:0] != 2'b11 never match a listed group, so they fall to the last arm
        bad     = op == OP_R    ? !(f7 == 7'd0 || (alt && (f3 == 3'd0 || f3 == 3'd5))) :
                  op == OP_IMM  ? (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && !alt) :
                  op == OP_LD   ? (f3 == 3'd3 || f3[2:1] == 2'b11) :
                  op == OP_ST   ? f3 > 3'd2 :
                  op == OP_BR   ? f3[2:1] == 2'b01 :
                  op == OP_JALR ? f3 != 3'd0 :
                  !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_SYS});
        ill     = ILLEGAL_CHECK && bad;
        imm32   = (op == OP_LD || op == OP_IMM || op == OP_JALR) ? {{20{ins[31]}}, ins[31:20]} :
                  op == OP_ST ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                  op == OP_BR ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
                  (op == OP_LUI || op == OP_AUIPC) ? {ins[31:12], 12'b0} :
                  op == OP_JAL ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} : 32'd0;
        dec.pc  = bus.in_pc;
        dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        dec.rs1 = ins[19:15];
        dec.rs2 = ins[24:20];
        dec.rd  = ins[11:7];
        dec.alu = ill ? 4'd0 : alu_raw;
        dec.ld  = !ill && op == OP_LD;
        dec.st  = !ill && op == OP_ST;
        dec.br  = !ill && op == OP_BR;
        dec.jmp = !ill && (op == OP_JAL || op == OP_JALR);
        dec.ill = ill;
    end
    assign acc       = bus.in_valid && !skid_v_q;
    assign cons      = main_v_q && bus.out_ready;
    assign load_main = !main_v_q || cons;
    // Skid can only be full while main is full, so an accept never coincides with a skid-to-main move
    always_comb begin
        main_v_d = !bus.flush && (load_main ? (skid_v_q || acc) : 1'b1);
        skid_v_d = !bus.flush && !load_main && (skid_v_q || acc);
        main_d   = !load_main ? main_q : skid_v_q ? skid_q : acc ? dec : main_q;
        skid_d   = (!load_main && acc) ? dec : skid_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end
    assign bus.in_ready  = !skid_v_q;
    assign bus.out_valid = main_v_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.imm       = main_q.imm;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.rd        = main_q.rd;
    assign bus.alu_ctrl  = main_q.alu;
    assign bus.is_load   = main_q.ld;
    assign bus.is_store  = main_q.st;
    assign bus.is_branch = main_q.br;
    assign bus.is_jump   = main_q.jmp;
    assign bus.illegal   = main_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage (XLEN 32 and 64)
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    decode_if #(.XLEN(32)) bus ();
    decode_if #(.XLEN(64)) bus64 ();
    decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_stage #(.XLEN(64), .ILLEGAL_CHECK(1'b0)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  fl;
    } e_t;
    e_t sb[$];
    e_t got;
    e_t exp_e;
    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask
    function automatic e_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] alu,
                              input logic [4:0] fl);
        return {pc, rs1, rs2, rd, imm, alu, fl};
    endfunction
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input e_t e);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        for (int i = 0; i < 20 && !bus.in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("accept", bus.in_ready, 1'b1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_empty", 128'(sb.size()), 128'd1);
            else begin
                exp_e = sb.pop_front();
                got = {bus.out_pc, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.alu_ctrl,
                       bus.is_load, bus.is_store, bus.is_branch, bus.is_jump, bus.illegal};
                chk("bundle", got, exp_e);
            end
        end
    end
    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.flush = 1'b0; bus64.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_imm", bus.imm, 32'd0);
        chk("rst_regs", {bus.rs1, bus.rs2, bus.rd}, 15'd0);
        chk("rst_alu", bus.alu_ctrl, 4'd0);
        chk("rst_flags", {bus.is_load, bus.is_store, bus.is_branch, bus.is_jump, bus.illegal}, 5'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'hFFF00093, 32'h100, mk(32'h100, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 4'd0, 5'b00000));
        chk("latency_out_valid", bus.out_valid, 1'b1);
        send(32'h402081B3, 32'h104, mk(32'h104, 5'd1, 5'd2, 5'd3, 32'h0, 4'd1, 5'b00000));
        send(32'hFE000EE3, 32'h108, mk(32'h108, 5'd0, 5'd0, 5'd29, 32'hFFFFFFFC, 4'd1, 5'b00100));
        send(32'h4010D093, 32'h10C, mk(32'h10C, 5'd1, 5'd1, 5'd1, 32'h401, 4'd7, 5'b00000));
        send(32'h008000EF, 32'h110, mk(32'h110, 5'd0, 5'd8, 5'd1, 32'h8, 4'd0, 5'b00010));
        send(32'h02208133, 32'h114, mk(32'h114, 5'd1, 5'd2, 5'd2, 32'h0, 4'd0, 5'b00001));
        send(32'h00000000, 32'h118, mk(32'h118, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 5'b00001));
        send(32'h0000707F, 32'h11C, mk(32'h11C, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 5'b00001));
        send(32'h00003003, 32'h120, mk(32'h120, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 5'b00001));
        send(32'h0020E863, 32'h124, mk(32'h124, 5'd1, 5'd2, 5'd16, 32'h10, 4'd9, 5'b00100));
        send(32'h7F037293, 32'h128, mk(32'h128, 5'd6, 5'd16, 5'd5, 32'h7F0, 4'd4, 5'b00000));
        repeat (2) @(posedge clk);
        #1;
        chk("drain_stream", 128'(sb.size()), 128'd0);
        bus.out_ready = 1'b0;
        send(32'h123453B7, 32'h300, mk(32'h300, 5'd8, 5'd3, 5'd7, 32'h12345000, 4'd0, 5'b00000));
        send(32'hFF812403, 32'h304, mk(32'h304, 5'd2, 5'd24, 5'd8, 32'hFFFFFFF8, 4'd0, 5'b10000));
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0091A623;
        bus.in_pc    = 32'h308;
        #0;
        chk("stall_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_hold_pc", bus.out_pc, 32'h300);
        chk("stall_hold_valid", bus.out_valid, 1'b1);
        chk("stall_in_ready2", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        send(32'h0091A623, 32'h308, mk(32'h308, 5'd3, 5'd9, 5'd12, 32'hC, 4'd0, 5'b01000));
        repeat (3) @(posedge clk);
        #1;
        chk("drain_stall", 128'(sb.size()), 128'd0);
        bus.out_ready = 1'b0;
        send(32'h123453B7, 32'h500, mk(32'h500, 5'd8, 5'd3, 5'd7, 32'h12345000, 4'd0, 5'b00000));
        send(32'h123453B7, 32'h504, mk(32'h504, 5'd8, 5'd3, 5'd7, 32'h12345000, 4'd0, 5'b00000));
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h508;
        bus.flush    = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_full_out_valid", bus.out_valid, 1'b0);
        chk("flush_full_in_ready", bus.in_ready, 1'b1);
        send(32'h123453B7, 32'h600, mk(32'h600, 5'd8, 5'd3, 5'd7, 32'h12345000, 4'd0, 5'b00000));
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h604;
        bus.flush    = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_accept_out_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_leak", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        send(32'h123453B7, 32'h700, mk(32'h700, 5'd8, 5'd3, 5'd7, 32'h12345000, 4'd0, 5'b00000));
        send(32'h123453B7, 32'h704, mk(32'h704, 5'd8, 5'd3, 5'd7, 32'h12345000, 4'd0, 5'b00000));
        #2 rst = 1'b1;
        #1;
        sb.delete();
        chk("rst_stall_out_valid", bus.out_valid, 1'b0);
        chk("rst_stall_in_ready", bus.in_ready, 1'b1);
        chk("rst_stall_out_pc", bus.out_pc, 32'd0);
        chk("rst_stall_imm", bus.imm, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'hFFF00093, 32'h400, mk(32'h400, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 4'd0, 5'b00000));
        chk("post_rst_latency", bus.out_valid, 1'b1);
        chk("post_rst_pc", bus.out_pc, 32'h400);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_post_rst", 128'(sb.size()), 128'd0);
        bus64.out_ready = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = 32'hFFF00093;
        bus64.in_pc     = 64'h100;
        @(posedge clk);
        #1;
        chk("x64_out_valid", bus64.out_valid, 1'b1);
        chk("x64_imm", bus64.imm, 64'hFFFFFFFFFFFFFFFF);
        chk("x64_rd", bus64.rd, 5'd1);
        bus64.in_instr = 32'h00000000;
        @(posedge clk);
        #1;
        chk("x64_nocheck_illegal", bus64.illegal, 1'b0);
        bus64.in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
